// File: rtl/siphash_pkg.sv
// Shared types and constants for the SipHash message feeder and its block assembler.
package siphash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_COLLECT,
        ST_COMP,
        ST_CWAIT,
        ST_LASTBLK,
        ST_FIN,
        ST_FWAIT
    } feeder_state_e;

    typedef enum logic [2:0] {
        ASM_NOP,
        ASM_BYTE,
        ASM_LEN,
        ASM_CLEAR_BLK,
        ASM_CLEAR_ALL
    } asm_op_e;

    localparam int         SIPHASH_BLOCK_BYTES = 8;
    localparam int         LEN_BYTE_POS        = 56;
    localparam logic [3:0] DEF_COMP_ROUNDS     = 4'd2;
    localparam logic [3:0] DEF_FINAL_ROUNDS    = 4'd4;

endpackage

// File: rtl/siphash_msg_feeder_if.sv
// Byte-stream valid/ready handshake into the SipHash message feeder.
interface siphash_msg_feeder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/siphash_block_assembler.sv
// Little-endian 64-bit block builder: byte index, mi register and 8-bit message length.
module siphash_block_assembler
    import siphash_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  asm_op_e     op,
    input  logic [7:0]  byte_in,
    output logic [63:0] mi,
    output logic [2:0]  idx
);

    logic [63:0] mi_q, mi_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d;

    always_comb begin
        mi_d  = mi_q;
        idx_d = idx_q;
        len_d = len_q;
        case (op)
            ASM_BYTE: begin
                mi_d[{idx_q, 3'b000} +: 8] = byte_in;
                idx_d = idx_q + 3'd1;
                len_d = len_q + 8'd1;
            end
            // Unfilled bytes were cleared earlier, so only the top byte needs writing.
            ASM_LEN: mi_d[LEN_BYTE_POS +: 8] = len_q;
            ASM_CLEAR_BLK: begin
                mi_d  = '0;
                idx_d = '0;
            end
            ASM_CLEAR_ALL: begin
                mi_d  = '0;
                idx_d = '0;
                len_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mi_q  <= '0;
            idx_q <= '0;
            len_q <= '0;
        end else begin
            mi_q  <= mi_d;
            idx_q <= idx_d;
            len_q <= len_d;
        end
    end

    assign mi  = mi_q;
    assign idx = idx_q;

endmodule

// File: rtl/siphash_msg_feeder.sv
// Feeds one message into siphash_core: packs bytes, appends the length block,
// sequences initalize/compress/finalize against core_ready and captures the digest.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | core_initalize strobe
// COLLECT | accepting message bytes
// COMP    | waiting for core_ready before compress
// CWAIT   | compress strobe issued, waiting for core to finish
// LASTBLK | writing length byte into the final block
// FIN     | waiting for core_ready before finalize
// FWAIT   | waiting for core_word_valid
module siphash_msg_feeder
    import siphash_pkg::*;
#(
    parameter logic [3:0] COMP_ROUNDS  = DEF_COMP_ROUNDS,
    parameter logic [3:0] FINAL_ROUNDS = DEF_FINAL_ROUNDS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  start_empty,
    input  logic                  long_mode,
    input  logic [127:0]          key,
    siphash_msg_feeder_if.slave   msg,
    output logic                  busy,
    output logic                  core_initalize,
    output logic                  core_compress,
    output logic                  core_finalize,
    output logic                  core_long,
    output logic [127:0]          core_key,
    output logic [63:0]           core_mi,
    output logic [3:0]            core_compression_rounds,
    output logic [3:0]            core_final_rounds,
    input  logic                  core_ready,
    input  logic [127:0]          core_word,
    input  logic                  core_word_valid,
    output logic [127:0]          digest,
    output logic                  digest_valid
);

    feeder_state_e state_q, state_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;
    logic          initalize_q, initalize_d;
    logic          compress_q, compress_d;
    logic          finalize_q, finalize_d;
    logic          long_q, long_d;
    logic          empty_q, empty_d;
    logic          pend_last_q, pend_last_d;
    logic          final_sent_q, final_sent_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  digest_q, digest_d;
    logic          dvalid_q, dvalid_d;
    logic [3:0]    crounds_q, crounds_d;
    logic [3:0]    frounds_q, frounds_d;

    asm_op_e       asm_op;
    logic [63:0]   asm_mi;
    logic [2:0]    asm_idx;

    siphash_block_assembler u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (asm_op),
        .byte_in (msg.in_data),
        .mi      (asm_mi),
        .idx     (asm_idx)
    );

    always_comb begin
        state_d      = state_q;
        initalize_d  = 1'b0;
        compress_d   = 1'b0;
        finalize_d   = 1'b0;
        long_d       = long_q;
        empty_d      = empty_q;
        pend_last_d  = pend_last_q;
        final_sent_d = final_sent_q;
        key_d        = key_q;
        digest_d     = digest_q;
        dvalid_d     = dvalid_q;
        crounds_d    = crounds_q;
        frounds_d    = frounds_q;
        asm_op       = ASM_NOP;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d        = key;
                    long_d       = long_mode;
                    empty_d      = start_empty;
                    dvalid_d     = 1'b0;
                    pend_last_d  = 1'b0;
                    final_sent_d = 1'b0;
                    crounds_d    = COMP_ROUNDS;
                    frounds_d    = FINAL_ROUNDS;
                    asm_op       = ASM_CLEAR_ALL;
                    initalize_d  = 1'b1;
                    state_d      = ST_INIT;
                end
            end
            ST_INIT: state_d = empty_q ? ST_LASTBLK : ST_COLLECT;
            ST_COLLECT: begin
                if (msg.in_valid && in_ready_q) begin
                    asm_op = ASM_BYTE;
                    if (asm_idx == 3'(SIPHASH_BLOCK_BYTES - 1)) begin
                        pend_last_d = msg.in_last;
                        state_d     = ST_COMP;
                    end else if (msg.in_last) begin
                        state_d = ST_LASTBLK;
                    end
                end
            end
            ST_COMP: begin
                if (core_ready) begin
                    compress_d = 1'b1;
                    state_d    = ST_CWAIT;
                end
            end
            // Ignore ready during the strobe cycle itself; the core only drops it afterwards.
            ST_CWAIT: begin
                if (core_ready && !compress_q) begin
                    asm_op = ASM_CLEAR_BLK;
                    if (final_sent_q)     state_d = ST_FIN;
                    else if (pend_last_q) state_d = ST_LASTBLK;
                    else                  state_d = ST_COLLECT;
                end
            end
            ST_LASTBLK: begin
                asm_op       = ASM_LEN;
                final_sent_d = 1'b1;
                state_d      = ST_COMP;
            end
            ST_FIN: begin
                if (core_ready) begin
                    finalize_d = 1'b1;
                    state_d    = ST_FWAIT;
                end
            end
            ST_FWAIT: begin
                if (core_word_valid && !finalize_q) begin
                    digest_d = core_word;
                    dvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            initalize_q  <= 1'b0;
            compress_q   <= 1'b0;
            finalize_q   <= 1'b0;
            long_q       <= 1'b0;
            empty_q      <= 1'b0;
            pend_last_q  <= 1'b0;
            final_sent_q <= 1'b0;
            key_q        <= '0;
            digest_q     <= '0;
            dvalid_q     <= 1'b0;
            crounds_q    <= '0;
            frounds_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            initalize_q  <= initalize_d;
            compress_q   <= compress_d;
            finalize_q   <= finalize_d;
            long_q       <= long_d;
            empty_q      <= empty_d;
            pend_last_q  <= pend_last_d;
            final_sent_q <= final_sent_d;
            key_q        <= key_d;
            digest_q     <= digest_d;
            dvalid_q     <= dvalid_d;
            crounds_q    <= crounds_d;
            frounds_q    <= frounds_d;
        end
    end

    assign msg.in_ready               = in_ready_q;
    assign busy                       = busy_q;
    assign core_initalize             = initalize_q;
    assign core_compress              = compress_q;
    assign core_finalize              = finalize_q;
    assign core_long                  = long_q;
    assign core_key                   = key_q;
    assign core_mi                    = asm_mi;
    assign core_compression_rounds    = crounds_q;
    assign core_final_rounds          = frounds_q;
    assign digest                     = digest_q;
    assign digest_valid               = dvalid_q;

endmodule

// File: tb/tb_siphash_msg_feeder.sv
// Bench for siphash_msg_feeder: behavioural SipHash core plus a message-level reference hash.
module tb_siphash_msg_feeder;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] blk_q_t[$];

    localparam int CR = 2;
    localparam int FR = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         start_empty = 1'b0;
    logic         long_mode = 1'b0;
    logic [127:0] key = '0;
    logic         busy, core_initalize, core_compress, core_finalize, core_long;
    logic [127:0] core_key, core_word, digest;
    logic [63:0]  core_mi;
    logic [3:0]   core_compression_rounds, core_final_rounds;
    logic         core_ready, core_word_valid, digest_valid;

    siphash_msg_feeder_if msg_if();

    siphash_msg_feeder dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .start_empty             (start_empty),
        .long_mode               (long_mode),
        .key                     (key),
        .msg                     (msg_if),
        .busy                    (busy),
        .core_initalize          (core_initalize),
        .core_compress           (core_compress),
        .core_finalize           (core_finalize),
        .core_long               (core_long),
        .core_key                (core_key),
        .core_mi                 (core_mi),
        .core_compression_rounds (core_compression_rounds),
        .core_final_rounds       (core_final_rounds),
        .core_ready              (core_ready),
        .core_word               (core_word),
        .core_word_valid         (core_word_valid),
        .digest                  (digest),
        .digest_valid            (digest_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int n);
        logic [63:0] v0, v1, v2, v3;
        {v3, v2, v1, v0} = s;
        for (int r = 0; r < n; r++) begin
            v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
            v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
            v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
            v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        end
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [255:0] sip_init(input logic [127:0] k, input logic lm);
        logic [63:0] v1;
        v1 = k[127:64] ^ 64'h646f72616e646f6d;
        if (lm) v1 = v1 ^ 64'hee;
        return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
                v1, k[63:0] ^ 64'h736f6d6570736575};
    endfunction

    function automatic logic [255:0] sip_absorb(input logic [255:0] s, input logic [63:0] m, input int n);
        logic [255:0] t;
        t = s;
        t[255:192] = t[255:192] ^ m;
        t = sip_rounds(t, n);
        t[63:0] = t[63:0] ^ m;
        return t;
    endfunction

    function automatic logic [127:0] sip_final(input logic [255:0] s, input logic lm, input int d);
        logic [255:0] t;
        logic [63:0]  h0, h1;
        t = s;
        t[191:128] = t[191:128] ^ (lm ? 64'hee : 64'hff);
        t = sip_rounds(t, d);
        h0 = t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
        if (!lm) return {64'h0, h0};
        t[127:64] = t[127:64] ^ 64'hdd;
        t = sip_rounds(t, d);
        h1 = t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
        return {h1, h0};
    endfunction

    function automatic blk_q_t exp_blocks(input byte_q_t m);
        blk_q_t      q;
        logic [63:0] w;
        int          n;
        n = m.size();
        for (int b = 0; b < n / 8; b++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = w | (64'(m[8*b+k]) << (8*k));
            q.push_back(w);
        end
        w = 64'(n % 256) << 56;
        for (int k = 0; k < n % 8; k++) w = w | (64'(m[8*(n/8)+k]) << (8*k));
        q.push_back(w);
        return q;
    endfunction

    function automatic logic [127:0] ref_hash(input logic [127:0] k, input logic lm, input byte_q_t m);
        blk_q_t       bq;
        logic [255:0] s;
        bq = exp_blocks(m);
        s  = sip_init(k, lm);
        foreach (bq[i]) s = sip_absorb(s, bq[i], CR);
        return sip_final(s, lm, FR);
    endfunction

    // Behavioural core and protocol monitor, evaluated mid-cycle.
    logic [255:0] cv;
    logic [127:0] fin_word;
    int           ccnt;
    bit           fin_pend;
    int           n_init = 0, n_comp = 0, n_fin = 0, strobe_err = 0, rdy_err = 0;
    blk_q_t       mi_log;

    always @(negedge clk) begin
        if (!reset_n) begin
            core_ready      = 1'b1;
            core_word_valid = 1'b0;
            core_word       = '0;
            ccnt            = 0;
            fin_pend        = 0;
        end else begin
            core_word_valid = 1'b0;
            if (int'(core_initalize) + int'(core_compress) + int'(core_finalize) > 1) strobe_err++;
            if ((core_initalize || core_compress || core_finalize) && !core_ready) strobe_err++;
            if (msg_if.in_ready && (!core_ready || core_compress)) rdy_err++;
            if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) begin
                    core_ready = 1'b1;
                    if (fin_pend) begin
                        core_word       = fin_word;
                        core_word_valid = 1'b1;
                        fin_pend        = 0;
                    end
                end
            end
            if (core_initalize) begin
                cv = sip_init(core_key, core_long);
                n_init++;
            end
            if (core_compress) begin
                mi_log.push_back(core_mi);
                cv = sip_absorb(cv, core_mi, int'(core_compression_rounds));
                core_ready = 1'b0;
                ccnt = int'(core_compression_rounds) + int'($urandom_range(0, 2));
                n_comp++;
            end
            if (core_finalize) begin
                fin_word   = sip_final(cv, core_long, int'(core_final_rounds));
                fin_pend   = 1;
                core_ready = 1'b0;
                ccnt       = int'(core_final_rounds) + 1;
                n_fin++;
            end
        end
    end

    task automatic run_msg(input string tag, input logic [127:0] k, input logic lm,
                           input byte_q_t m, input int gap_pct, input int extra_starts);
        blk_q_t       eb;
        logic [127:0] eh;
        int           b_init, b_comp, b_fin, b_se, b_re, base, i, budget;
        eb     = exp_blocks(m);
        eh     = ref_hash(k, lm, m);
        b_init = n_init; b_comp = n_comp; b_fin = n_fin;
        b_se   = strobe_err; b_re = rdy_err;
        base   = mi_log.size();

        @(negedge clk);
        key = k; long_mode = lm; start_empty = (m.size() == 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        chk({tag, "_dvalid_clr"}, 128'(digest_valid), 128'(0));
        for (int e = 0; e < extra_starts; e++) begin
            long_mode = ~lm; start_empty = ~start_empty; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_key"}, core_key, k);
        chk({tag, "_long"}, 128'(core_long), 128'(lm));
        chk({tag, "_rounds"}, 128'({core_compression_rounds, core_final_rounds}), 128'({4'(CR), 4'(FR)}));

        i = 0; budget = 0;
        while (i < m.size() && budget < 4000) begin
            msg_if.in_valid = ($urandom_range(0, 99) >= gap_pct);
            msg_if.in_data  = msg_if.in_valid ? m[i] : 8'($urandom);
            msg_if.in_last  = msg_if.in_valid ? (i == m.size() - 1) : 1'($urandom);
            if (msg_if.in_valid && msg_if.in_ready) i++;
            @(negedge clk);
            budget++;
        end
        msg_if.in_valid = 1'b0;
        msg_if.in_last  = 1'b0;
        if (i < m.size()) chk({tag, "_bytes_timeout"}, 128'(i), 128'(m.size()));

        budget = 0;
        while (!digest_valid && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_dvalid"}, 128'(digest_valid), 128'(1));
        chk({tag, "_digest"}, digest, eh);
        chk({tag, "_idle"}, 128'(busy), 128'(0));
        chk({tag, "_n_init"}, 128'(n_init - b_init), 128'(1));
        chk({tag, "_n_fin"}, 128'(n_fin - b_fin), 128'(1));
        chk({tag, "_n_comp"}, 128'(n_comp - b_comp), 128'(eb.size()));
        chk({tag, "_strobe_rules"}, 128'(strobe_err - b_se), 128'(0));
        chk({tag, "_in_ready_rules"}, 128'(rdy_err - b_re), 128'(0));
        for (int j = 0; j < eb.size(); j++)
            if (base + j < mi_log.size())
                chk($sformatf("%s_mi%0d", tag, j), 128'(mi_log[base+j]), 128'(eb[j]));
    endtask

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;

    initial begin
        byte_q_t      m;
        int           base, budget;
        logic [127:0] rk;

        msg_if.in_valid = 1'b0;
        msg_if.in_data  = 8'h00;
        msg_if.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 128'({busy, msg_if.in_ready, core_initalize, core_compress, core_finalize,
                               core_long, digest_valid, core_compression_rounds, core_final_rounds}), 128'(0));
        chk("reset_mi", 128'(core_mi), 128'(0));
        chk("reset_digest", digest, 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        m.delete();
        run_msg("t1", KAT_KEY, 1'b0, m, 0, 0);
        chk("t1_kat", 128'(digest[63:0]), 128'(64'h726fdb47dd0e0e31));

        for (int b = 0; b < 7; b++) m.push_back(8'(b));
        base = mi_log.size();
        run_msg("t2", KAT_KEY, 1'b0, m, 0, 0);
        chk("t2_blk0", 128'(mi_log[base]), 128'(64'h0706050403020100));

        m.push_back(8'h07);
        base = mi_log.size();
        run_msg("t3", KAT_KEY, 1'b0, m, 20, 0);
        chk("t3_blk0", 128'(mi_log[base]), 128'(64'h0706050403020100));
        chk("t3_blk1", 128'(mi_log[base+1]), 128'(64'h0800000000000000));

        for (int b = 8; b < 15; b++) m.push_back(8'(b));
        base = mi_log.size();
        run_msg("t4", KAT_KEY, 1'b0, m, 40, 0);
        chk("t4_blk1", 128'(mi_log[base+1]), 128'(64'h0f0e0d0c0b0a0908));

        m.delete();
        for (int b = 0; b < 256; b++) m.push_back(8'haa);
        base = mi_log.size();
        run_msg("t5", KAT_KEY ^ 128'h5a, 1'b1, m, 10, 0);
        chk("t5_final_blk", 128'(mi_log[base+32]), 128'(0));

        for (int r = 0; r < 5; r++) begin
            m.delete();
            for (int b = 0; b < int'($urandom_range(1, 40)); b++) m.push_back(8'($urandom));
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_msg($sformatf("rnd%0d", r), rk, 1'($urandom), m, 30, 1);
        end

        // Reset while the first compress of a long-mode empty message is in flight.
        base = n_comp;
        @(negedge clk);
        key = KAT_KEY ^ 128'h1234; long_mode = 1'b1; start_empty = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (n_comp == base && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("t6_reach_cwait", 128'(n_comp - base), 128'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 128'({busy, msg_if.in_ready, core_initalize, core_compress, core_finalize,
                                core_long, digest_valid, core_compression_rounds, core_final_rounds}), 128'(0));
        chk("t6_rst_key", core_key, 128'(0));
        chk("t6_rst_mi", 128'(core_mi), 128'(0));
        chk("t6_rst_digest", digest, 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m.delete();
        run_msg("t6_after", KAT_KEY, 1'b0, m, 0, 3);
        chk("t6_kat", 128'(digest[63:0]), 128'(64'h726fdb47dd0e0e31));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
